// File: rtl/rob_multiport_pkg.sv
// Shared types and configuration for the multi-port reorder buffer.
package rob_multiport_pkg;

  localparam int unsigned ROB_ENTRIES  = 16;
  localparam int unsigned DISP_WIDTH   = 2;
  localparam int unsigned WB_PORTS     = 4;
  localparam int unsigned RETIRE_WIDTH = 2;
  localparam int unsigned IDXW         = $clog2(ROB_ENTRIES);

  // Pointer with an extra wrap bit so full and empty are distinguishable.
  typedef logic [IDXW:0] rob_ptr_t;

  typedef struct packed {
    logic [4:0]  dest_reg;
    logic        wb_en;
    logic [31:0] pc;
    logic        mispred;
    logic        exception;
  } rob_entry_t;

  typedef struct packed {
    logic valid;
    logic ready;
  } rob_status_t;

endpackage

// File: rtl/rob_multiport_if.sv
// Dispatch / writeback / retire / flush bundle between the core and the ROB.
interface rob_multiport_if;
  import rob_multiport_pkg::*;

  logic [DISP_WIDTH-1:0]              disp_valid;
  rob_entry_t [DISP_WIDTH-1:0]        disp_entry;
  logic                               disp_ready;
  logic [DISP_WIDTH-1:0][IDXW-1:0]    disp_idx;

  logic [WB_PORTS-1:0]                wb_valid;
  logic [WB_PORTS-1:0][IDXW-1:0]      wb_idx;
  logic [WB_PORTS-1:0][31:0]          wb_result;
  logic [WB_PORTS-1:0]                wb_mispred;
  logic [WB_PORTS-1:0]                wb_exception;

  logic [RETIRE_WIDTH-1:0]            ret_valid;
  logic [RETIRE_WIDTH-1:0][4:0]       ret_dest_reg;
  logic [RETIRE_WIDTH-1:0]            ret_wb_en;
  logic [RETIRE_WIDTH-1:0][31:0]      ret_result;

  logic                               flush;
  logic [31:0]                        flush_pc;
  logic                               flush_exc;
  logic [IDXW:0]                      count;

  modport master (
    output disp_valid, disp_entry, wb_valid, wb_idx, wb_result, wb_mispred, wb_exception,
    input  disp_ready, disp_idx, ret_valid, ret_dest_reg, ret_wb_en, ret_result,
           flush, flush_pc, flush_exc, count
  );

  modport slave (
    input  disp_valid, disp_entry, wb_valid, wb_idx, wb_result, wb_mispred, wb_exception,
    output disp_ready, disp_idx, ret_valid, ret_dest_reg, ret_wb_en, ret_result,
           flush, flush_pc, flush_exc, count
  );

endinterface

// File: rtl/rob_multiport_retire_sel.sv
// In-order retire lane selection over the head window; stops after the first flushing lane.
module rob_retire_sel #(
  parameter int unsigned WIDTH = 2,
  parameter int unsigned LANEW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] win_valid,
  input  logic [WIDTH-1:0] win_ready,
  input  logic [WIDTH-1:0] win_flush,
  output logic [WIDTH-1:0] ret_valid,
  output logic             flush_hit,
  output logic [LANEW-1:0] flush_lane
);

  logic go;

  // Walk lanes oldest-first; a lane retires only if every older lane retired without flushing.
  always_comb begin
    ret_valid  = '0;
    flush_hit  = 1'b0;
    flush_lane = '0;
    go         = 1'b1;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      if (go && win_valid[k] && win_ready[k]) begin
        ret_valid[k] = 1'b1;
        if (win_flush[k]) begin
          flush_hit  = 1'b1;
          flush_lane = LANEW'(k);
          go         = 1'b0;
        end
      end else begin
        go = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rob_multiport.sv
// Reorder buffer: multi-lane in-order allocate, multi-port writeback, multi-lane in-order retire.
module rob_multiport
  import rob_multiport_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  rob_multiport_if.slave bus
);

  localparam int unsigned LANEW = (RETIRE_WIDTH > 1) ? $clog2(RETIRE_WIDTH) : 1;
  typedef logic [IDXW-1:0] idx_t;

  rob_ptr_t    head, tail, count;
  rob_entry_t  entry  [ROB_ENTRIES];
  logic [31:0] result [ROB_ENTRIES];
  rob_status_t status [ROB_ENTRIES];

  logic        flush_q, flush_exc_q;
  logic [31:0] flush_pc_q;

  idx_t     disp_slot [DISP_WIDTH];
  rob_ptr_t disp_n;
  logic     disp_fire;

  idx_t                    ret_idx [RETIRE_WIDTH];
  logic [RETIRE_WIDTH-1:0] win_valid, win_ready, win_flush, ret_valid;
  logic                    flush_hit;
  logic [LANEW-1:0]        flush_lane;
  idx_t                    flush_idx;
  rob_ptr_t                ret_n;
  logic                    wb_conflict;

  assign count          = tail - head;
  assign bus.count      = count;
  assign bus.disp_ready = (rob_ptr_t'(ROB_ENTRIES) - count) >= rob_ptr_t'(DISP_WIDTH);
  assign bus.flush      = flush_q;
  assign bus.flush_pc   = flush_pc_q;
  assign bus.flush_exc  = flush_exc_q;
  assign bus.ret_valid  = ret_valid;
  assign disp_fire      = bus.disp_ready && !flush_hit;
  assign flush_idx      = ret_idx[flush_lane];

  // Compact valid lanes onto consecutive slots starting at tail.
  always_comb begin
    disp_n = '0;
    for (int unsigned i = 0; i < DISP_WIDTH; i++) begin
      disp_slot[i]    = tail[IDXW-1:0] + disp_n[IDXW-1:0];
      bus.disp_idx[i] = disp_slot[i];
      disp_n          = disp_n + rob_ptr_t'(bus.disp_valid[i]);
    end
  end

  // Gather registered status of the head window.
  always_comb begin
    for (int unsigned k = 0; k < RETIRE_WIDTH; k++) begin
      ret_idx[k]   = head[IDXW-1:0] + idx_t'(k);
      win_valid[k] = status[ret_idx[k]].valid;
      win_ready[k] = status[ret_idx[k]].ready;
      win_flush[k] = entry[ret_idx[k]].mispred | entry[ret_idx[k]].exception;
    end
  end

  rob_retire_sel #(.WIDTH(RETIRE_WIDTH), .LANEW(LANEW)) u_retire_sel (
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .win_flush  (win_flush),
    .ret_valid  (ret_valid),
    .flush_hit  (flush_hit),
    .flush_lane (flush_lane)
  );

  // Commit payload and retired-lane count.
  always_comb begin
    ret_n = '0;
    for (int unsigned k = 0; k < RETIRE_WIDTH; k++) begin
      bus.ret_dest_reg[k] = entry[ret_idx[k]].dest_reg;
      bus.ret_wb_en[k]    = ret_valid[k] & entry[ret_idx[k]].wb_en & ~entry[ret_idx[k]].exception;
      bus.ret_result[k]   = result[ret_idx[k]];
      ret_n               = ret_n + rob_ptr_t'(ret_valid[k]);
    end
  end

  // Detect two writeback ports targeting the same entry in one cycle.
  always_comb begin
    wb_conflict = 1'b0;
    for (int unsigned p = 0; p < WB_PORTS; p++)
      for (int unsigned q = p + 1; q < WB_PORTS; q++)
        if (bus.wb_valid[p] && bus.wb_valid[q] && bus.wb_idx[p] == bus.wb_idx[q])
          wb_conflict = 1'b1;
  end

  a_wb_unique: assert property (@(posedge clk) disable iff (rst) !wb_conflict);

  // Pointers, per-entry status and flush pulse. Later statements override earlier ones:
  // writeback < retire < dispatch < flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head        <= '0;
      tail        <= '0;
      flush_q     <= 1'b0;
      flush_pc_q  <= '0;
      flush_exc_q <= 1'b0;
      for (int unsigned i = 0; i < ROB_ENTRIES; i++) status[i] <= '0;
    end else begin
      flush_q <= flush_hit;
      if (flush_hit) begin
        flush_pc_q  <= entry[flush_idx].pc;
        flush_exc_q <= entry[flush_idx].exception;
      end
      for (int unsigned p = 0; p < WB_PORTS; p++)
        if (bus.wb_valid[p] && status[bus.wb_idx[p]].valid)
          status[bus.wb_idx[p]].ready <= 1'b1;
      for (int unsigned k = 0; k < RETIRE_WIDTH; k++)
        if (ret_valid[k]) status[ret_idx[k]] <= '0;
      head <= head + ret_n;
      if (flush_hit) begin
        for (int unsigned i = 0; i < ROB_ENTRIES; i++) status[i] <= '0;
        tail <= head + ret_n;
      end else if (disp_fire) begin
        for (int unsigned i = 0; i < DISP_WIDTH; i++)
          if (bus.disp_valid[i]) status[disp_slot[i]] <= '{valid: 1'b1, ready: 1'b0};
        tail <= tail + disp_n;
      end
    end
  end

  // Entry payload and results; gated by status so stale writes never become visible.
  always_ff @(posedge clk) begin
    for (int unsigned p = 0; p < WB_PORTS; p++) begin
      if (bus.wb_valid[p] && status[bus.wb_idx[p]].valid) begin
        result[bus.wb_idx[p]]          <= bus.wb_result[p];
        entry[bus.wb_idx[p]].mispred   <= bus.wb_mispred[p];
        entry[bus.wb_idx[p]].exception <= bus.wb_exception[p];
      end
    end
    if (disp_fire) begin
      for (int unsigned i = 0; i < DISP_WIDTH; i++) begin
        if (bus.disp_valid[i]) begin
          entry[disp_slot[i]] <= '{dest_reg:  bus.disp_entry[i].dest_reg,
                                   wb_en:     bus.disp_entry[i].wb_en,
                                   pc:        bus.disp_entry[i].pc,
                                   mispred:   1'b0,
                                   exception: 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_rob_multiport.sv
// Directed, table-driven bench for rob_multiport.
module tb_rob_multiport;
  import rob_multiport_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rob_multiport_if bus ();

  rob_multiport dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  typedef struct {
    logic [1:0] dv;
    logic       exp_ready;
    logic [3:0] exp_i0;
    logic [3:0] exp_i1;
    logic [4:0] exp_cnt;
  } vec_t;

  vec_t fill [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  function automatic rob_entry_t mk(input logic [31:0] pc, input logic [4:0] d);
    return '{dest_reg: d, wb_en: 1'b1, pc: pc, mispred: 1'b0, exception: 1'b0};
  endfunction

  task automatic wb_clear();
    bus.wb_valid     = '0;
    bus.wb_idx       = '0;
    bus.wb_result    = '0;
    bus.wb_mispred   = '0;
    bus.wb_exception = '0;
  endtask

  task automatic wb_set(input int p, input logic [3:0] idx, input logic [31:0] res,
                        input logic mis, input logic exc);
    bus.wb_valid[p]     = 1'b1;
    bus.wb_idx[p]       = idx;
    bus.wb_result[p]    = res;
    bus.wb_mispred[p]   = mis;
    bus.wb_exception[p] = exc;
  endtask

  task automatic disp(input logic [1:0] dv, input logic [31:0] pc0, input logic [31:0] pc1);
    bus.disp_valid    = dv;
    bus.disp_entry[0] = mk(pc0, pc0[6:2]);
    bus.disp_entry[1] = mk(pc1, pc1[6:2]);
  endtask

  task automatic do_reset();
    rst            = 1'b1;
    bus.disp_valid = '0;
    wb_clear();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned retired;
    int unsigned nidx;
    logic [3:0] prev0, prev1;

    fill = '{
      '{2'b01, 1'b1, 4'd0,  4'd1,  5'd1 },
      '{2'b10, 1'b1, 4'd1,  4'd1,  5'd2 },
      '{2'b11, 1'b1, 4'd2,  4'd3,  5'd4 },
      '{2'b11, 1'b1, 4'd4,  4'd5,  5'd6 },
      '{2'b11, 1'b1, 4'd6,  4'd7,  5'd8 },
      '{2'b11, 1'b1, 4'd8,  4'd9,  5'd10},
      '{2'b11, 1'b1, 4'd10, 4'd11, 5'd12},
      '{2'b11, 1'b1, 4'd12, 4'd13, 5'd14},
      '{2'b11, 1'b1, 4'd14, 4'd15, 5'd16},
      '{2'b11, 1'b0, 4'd0,  4'd1,  5'd16},
      '{2'b01, 1'b0, 4'd0,  4'd1,  5'd16}
    };

    bus.disp_valid = '0;
    bus.disp_entry = '0;
    wb_clear();
    tick();
    tick();
    rst = 1'b0;
    settle();
    chk("rst count", bus.count, 0);
    chk("rst disp_ready", bus.disp_ready, 1);
    chk("rst ret_valid", bus.ret_valid, 0);
    chk("rst flush", bus.flush, 0);
    chk("rst flush_pc", bus.flush_pc, 0);
    chk("rst flush_exc", bus.flush_exc, 0);

    // Fill with no writeback
    for (int i = 0; i < 11; i++) begin
      disp(fill[i].dv, 32'h1000 + 32'(i * 8), 32'h1004 + 32'(i * 8));
      settle();
      chk($sformatf("fill%0d ready", i), bus.disp_ready, fill[i].exp_ready);
      chk($sformatf("fill%0d idx0", i), bus.disp_idx[0], fill[i].exp_i0);
      chk($sformatf("fill%0d idx1", i), bus.disp_idx[1], fill[i].exp_i1);
      chk($sformatf("fill%0d ret_valid", i), bus.ret_valid, 0);
      tick();
      chk($sformatf("fill%0d count", i), bus.count, fill[i].exp_cnt);
    end

    // Reach 15 entries: a single free slot is not enough for a dispatch group
    do_reset();
    for (int i = 0; i < 7; i++) begin
      disp(2'b11, 32'h40, 32'h44);
      tick();
    end
    disp(2'b01, 32'h48, 32'h4c);
    tick();
    disp(2'b11, 32'h50, 32'h54);
    settle();
    chk("c15 count", bus.count, 15);
    chk("c15 ready", bus.disp_ready, 0);
    tick();
    chk("c15 count held", bus.count, 15);

    // Out-of-order writeback
    do_reset();
    disp(2'b11, 32'h100, 32'h104);
    tick();
    disp(2'b01, 32'h108, 32'h10c);
    tick();
    bus.disp_valid = '0;
    wb_set(0, 4'd2, 32'hA2, 1'b0, 1'b0);
    tick();
    wb_clear();
    wb_set(0, 4'd1, 32'hA1, 1'b0, 1'b0);
    settle();
    chk("ooo ret after wb2", bus.ret_valid, 0);
    tick();
    wb_clear();
    wb_set(0, 4'd0, 32'hA0, 1'b0, 1'b0);
    settle();
    chk("ooo ret after wb1", bus.ret_valid, 0);
    tick();
    wb_clear();
    settle();
    chk("ooo ret01 valid", bus.ret_valid, 2'b11);
    chk("ooo ret0 result", bus.ret_result[0], 32'hA0);
    chk("ooo ret1 result", bus.ret_result[1], 32'hA1);
    chk("ooo ret0 dest", bus.ret_dest_reg[0], 5'h00);
    chk("ooo ret1 dest", bus.ret_dest_reg[1], 5'h01);
    chk("ooo ret wb_en", bus.ret_wb_en, 2'b11);
    tick();
    chk("ooo ret2 valid", bus.ret_valid, 2'b01);
    chk("ooo ret2 result", bus.ret_result[0], 32'hA2);
    chk("ooo count mid", bus.count, 1);
    tick();
    chk("ooo count end", bus.count, 0);
    chk("ooo ret end", bus.ret_valid, 0);

    // Mispredict on entry 3
    do_reset();
    disp(2'b11, 32'h200, 32'h204);
    tick();
    disp(2'b11, 32'h208, 32'h20c);
    tick();
    disp(2'b11, 32'h210, 32'h214);
    tick();
    bus.disp_valid = '0;
    chk("mis count6", bus.count, 6);
    wb_set(0, 4'd1, 32'hB1, 1'b0, 1'b0);
    wb_set(1, 4'd2, 32'hB2, 1'b0, 1'b0);
    wb_set(2, 4'd3, 32'hB3, 1'b1, 1'b0);
    wb_set(3, 4'd4, 32'hB4, 1'b0, 1'b0);
    tick();
    wb_clear();
    wb_set(0, 4'd5, 32'hB5, 1'b0, 1'b0);
    settle();
    chk("mis no ret", bus.ret_valid, 0);
    tick();
    wb_clear();
    wb_set(0, 4'd0, 32'hB0, 1'b0, 1'b0);
    tick();
    wb_clear();
    settle();
    chk("mis ret01", bus.ret_valid, 2'b11);
    chk("mis ret0 result", bus.ret_result[0], 32'hB0);
    tick();
    chk("mis ret23", bus.ret_valid, 2'b11);
    chk("mis ret3 result", bus.ret_result[1], 32'hB3);
    chk("mis no flush yet", bus.flush, 0);
    tick();
    chk("mis flush", bus.flush, 1);
    chk("mis flush_pc", bus.flush_pc, 32'h20c);
    chk("mis flush_exc", bus.flush_exc, 0);
    chk("mis count0", bus.count, 0);
    chk("mis no ret 4/5", bus.ret_valid, 0);
    tick();
    chk("mis flush pulse end", bus.flush, 0);
    chk("mis flush_pc held", bus.flush_pc, 32'h20c);
    chk("mis ret stays idle", bus.ret_valid, 0);

    // Exception at head with concurrent dispatch
    do_reset();
    disp(2'b01, 32'h300, 32'h304);
    tick();
    bus.disp_valid = '0;
    wb_set(2, 4'd0, 32'hDEAD, 1'b0, 1'b1);
    tick();
    wb_clear();
    disp(2'b11, 32'h308, 32'h30c);
    settle();
    chk("exc ret_valid", bus.ret_valid, 2'b01);
    chk("exc ret_wb_en", bus.ret_wb_en, 2'b00);
    chk("exc disp_ready", bus.disp_ready, 1);
    tick();
    disp(2'b11, 32'h400, 32'h404);
    settle();
    chk("exc flush", bus.flush, 1);
    chk("exc flush_exc", bus.flush_exc, 1);
    chk("exc flush_pc", bus.flush_pc, 32'h300);
    chk("exc count0", bus.count, 0);
    chk("exc redirect idx0", bus.disp_idx[0], 4'd1);
    chk("exc redirect idx1", bus.disp_idx[1], 4'd2);
    tick();
    bus.disp_valid = '0;
    chk("exc redirect count", bus.count, 2);
    chk("exc flush end", bus.flush, 0);

    // Stream 40 instructions, wrap indices
    do_reset();
    retired = 0;
    nidx    = 0;
    prev0   = '0;
    prev1   = '0;
    for (int c = 0; c < 20; c++) begin
      disp(2'b11, 32'h800 + 32'(c * 8), 32'h804 + 32'(c * 8));
      wb_clear();
      if (c > 0) begin
        wb_set(0, prev0, 32'(c * 2 - 2), 1'b0, 1'b0);
        wb_set(1, prev1, 32'(c * 2 - 1), 1'b0, 1'b0);
      end
      settle();
      chk($sformatf("wrap%0d ready", c), bus.disp_ready, 1);
      chk($sformatf("wrap%0d idx0", c), bus.disp_idx[0], 4'(nidx % 16));
      chk($sformatf("wrap%0d idx1", c), bus.disp_idx[1], 4'((nidx + 1) % 16));
      prev0 = bus.disp_idx[0];
      prev1 = bus.disp_idx[1];
      retired += $countones(bus.ret_valid);
      tick();
      chk($sformatf("wrap%0d count<=16", c), bus.count <= 5'd16, 1);
      nidx += 2;
    end
    bus.disp_valid = '0;
    wb_clear();
    wb_set(0, prev0, 32'd38, 1'b0, 1'b0);
    wb_set(1, prev1, 32'd39, 1'b0, 1'b0);
    settle();
    retired += $countones(bus.ret_valid);
    tick();
    wb_clear();
    for (int d = 0; d < 4; d++) begin
      settle();
      retired += $countones(bus.ret_valid);
      tick();
    end
    chk("wrap retired", retired, 40);
    chk("wrap drained", bus.count, 0);

    // Asynchronous reset with 10 entries live
    for (int i = 0; i < 5; i++) begin
      disp(2'b11, 32'h900, 32'h904);
      tick();
    end
    bus.disp_valid = '0;
    chk("live count10", bus.count, 10);
    #2;
    rst = 1'b1;
    #1;
    chk("async rst count", bus.count, 0);
    chk("async rst ready", bus.disp_ready, 1);
    chk("async rst ret", bus.ret_valid, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("post rst count", bus.count, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
